// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module : counter_pkg
// Brief  : Shared constants and helpers for the counter_4b up-counter.
// Rev    : 1.0  initial release
// ============================================================================
package counter_pkg;

  localparam int CNT_W_DEFAULT = 4;

  // All-ones value for a counter of the given width (width < 32).
  function automatic int unsigned cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_4b.sv
`default_nettype none
// ============================================================================
// Module : counter_4b
// Brief  : Free-running modulo-2^WIDTH up-counter with synchronous count
//          enable, asynchronous active-low clear and terminal-count flag.
// Rev    : 1.0  initial release
// ============================================================================
module counter_4b
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(cnt_max(WIDTH));
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] w_next;

  // Natural overflow of the WIDTH-bit add gives the wrap to zero.
  assign w_next = q + C_ONE;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= '0;
    end else if (ce) begin
      q <= w_next;
    end
  end

  assign tc = clr & ce & (q == C_MAX);

endmodule : counter_4b
`default_nettype wire

// File: tb/tb_counter_4b.sv
`default_nettype none
// ============================================================================
// Module : tb_counter_4b
// Brief  : Directed and randomized self-checking bench for counter_4b.
// Rev    : 1.0  initial release
// ============================================================================
module tb_counter_4b;
  import counter_pkg::*;

  localparam int W   = CNT_W_DEFAULT;
  localparam int MOD = 1 << W;
  localparam int MAX = MOD - 1;

  logic         clk;
  logic         clr;
  logic         ce;
  logic [W-1:0] q;
  logic         tc;

  int checks   = 0;
  int failures = 0;
  int mdl      = 0;   // reference count value

  counter_4b #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .ce  (ce),
    .q   (q),
    .tc  (tc)
  );

  // Clock begins unknown, then toggles with a 10 ns period.
  initial begin
    clk = 1'bx;
    #7;
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive ce, check tc before the edge, advance model, check q after.
  task automatic cycle(input logic ce_v, input string tag);
    ce = ce_v;
    #1;
    chk({tag, "_tc"}, {31'd0, tc}, {31'd0, (clr && ce && mdl == MAX)});
    @(posedge clk);
    if (!clr)    mdl = 0;
    else if (ce) mdl = (mdl + 1) % MOD;
    #1;
    chk({tag, "_q"}, {{(32-W){1'b0}}, q}, mdl);
  endtask

  initial begin
    int  guard;
    logic hold_low;
    clr = 1'b0;
    ce  = 1'b0;

    // Power-up reset with clock still unknown
    #3;
    chk("por_q",  {{(32-W){1'b0}}, q}, 0);
    chk("por_tc", {31'd0, tc}, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, "por");
    cycle(1'b1, "por_ce1");

    // Release with ce low: no counting
    clr = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, "rel_hold");
    chk("rel_q0", {{(32-W){1'b0}}, q}, 0);

    // Straight count 1..10
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, "count");
      chk("count_abs", {{(32-W){1'b0}}, q}, i + 1);
    end

    // Wrap-around; tc checked inside cycle against the model
    for (int i = 0; i < 20; i++) cycle(1'b1, "wrap");

    // Advance to 7, then clear asynchronously between edges
    guard = 0;
    while (mdl != 7 && guard < 2 * MOD) begin
      cycle(1'b1, "to7");
      guard++;
    end
    chk("reach7", {{(32-W){1'b0}}, q}, 7);
    ce = 1'b1;
    #2;
    clr = 1'b0;
    #1;
    mdl = 0;
    chk("async_q", {{(32-W){1'b0}}, q}, 0);
    chk("async_tc", {31'd0, tc}, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, "in_clr");

    // Release, then alternate ce starting from zero
    clr = 1'b1;
    for (int i = 0; i < 8; i++) cycle(((i % 2) == 0), "toggle");
    chk("toggle_end", {{(32-W){1'b0}}, q}, 4);

    // Randomized enable with occasional asynchronous clear pulses
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        #2;
        clr = 1'b0;
        #1;
        mdl = 0;
        chk("rnd_async", {{(32-W){1'b0}}, q}, 0);
        hold_low = 1'b1;
        cycle(logic'($urandom_range(0, 1)), "rnd_inclr");
        if (hold_low) clr = 1'b1;
      end
      cycle(($urandom_range(0, 3) != 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_counter_4b
`default_nettype wire
